// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: numbers with a sticky error
// flag, ALU operators and front-end command kinds.
package calc_pkg;

    localparam int NUM_W = 16;

    // A calculator value: magnitude plus an error flag that travels with it.
    typedef struct packed {
        logic             error;
        logic [NUM_W-1:0] value;
    } num_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    typedef enum logic [1:0] {
        CMD_LOAD,
        CMD_APPLY,
        CMD_CLEAR
    } cmd_kind_t;

    localparam num_t NUM_ZERO = '0;

    // An APPLY reaches the ALU only from a clean accumulator with a real operator.
    function automatic logic apply_issues(num_t acc, op_t op);
        return !acc.error && (op != OP_NONE);
    endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Requester side of the ALU valid/ready interface. Owns the accumulator,
// turns keypad commands into ALU requests and writes results back.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  cmd_kind_t cmd_kind_i,
    input  num_t      cmd_num_i,
    input  op_t       cmd_op_i,
    input  logic      cmd_valid_i,
    output logic      cmd_ready_o,
    output num_t      alu_left_o,
    output num_t      alu_right_o,
    output op_t       alu_op_o,
    output logic      alu_in_valid_o,
    input  logic      alu_in_ready_i,
    input  num_t      alu_result_i,
    input  logic      alu_out_valid_i,
    output logic      alu_out_ready_o,
    output num_t      acc_o,
    output logic      busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    // A zero timeout disables the check; keep the counter one bit wide then.
    localparam int TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W:0] TIMEOUT_VAL = (TIMER_W + 1)'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    num_t               acc_q, acc_d;
    num_t               left_q, left_d;
    num_t               right_q, right_d;
    op_t                op_q, op_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Wait cycles elapsed including the current one; the extra MSB flags saturation.
    logic [TIMER_W:0]   timer_inc;
    logic               timeout_hit;

    assign timer_inc   = {1'b0, timer_q} + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_inc == TIMEOUT_VAL);

    // Next-state logic for the FSM, accumulator, operand latch and wait timer.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // signal unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        acc_d   = acc_q;
        left_d  = left_q;
        right_d = right_q;
        op_d    = op_q;
        timer_d = timer_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_kind_i)
                        CMD_LOAD:  acc_d = cmd_num_i;
                        CMD_CLEAR: acc_d = NUM_ZERO;
                        CMD_APPLY: begin
                            // Errored accumulator or OP_NONE: swallow the command silently.
                            if (apply_issues(acc_q, cmd_op_i)) begin
                                left_d  = acc_q;
                                right_d = cmd_num_i;
                                op_d    = cmd_op_i;
                                state_d = S_REQ;
                            end
                        end
                        default: ;  // unknown kind is consumed with no effect
                    endcase
                end
            end

            S_REQ: begin
                if (alu_in_ready_i) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (alu_out_valid_i) begin
                    acc_d   = alu_result_i;
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    acc_d.error = 1'b1;
                    state_d     = S_IDLE;
                end else if (!timer_inc[TIMER_W]) begin
                    timer_d = timer_inc[TIMER_W-1:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples the pre-edge value of every other register.
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Accumulator register (display value and sticky error).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) acc_q <= NUM_ZERO;
        else       acc_q <= acc_d;
    end

    // Operand latch presented to the ALU; held stable through S_REQ and S_WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            left_q  <= NUM_ZERO;
            right_q <= NUM_ZERO;
            op_q    <= OP_NONE;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            op_q    <= op_d;
        end
    end

    // Wait-cycle timer for the result timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    // Handshake and status outputs are pure decodes of the state register.
    assign cmd_ready_o     = (state_q == S_IDLE);
    assign alu_in_valid_o  = (state_q == S_REQ);
    assign alu_out_ready_o = (state_q == S_WAIT);
    assign busy_o          = (state_q != S_IDLE);
    assign alu_left_o      = left_q;
    assign alu_right_o     = right_q;
    assign alu_op_o        = op_q;
    assign acc_o           = acc_q;

endmodule
